debouncer: RTL and testbench

Input conditioner that sits directly upstream of the edge detector in the trigger path. It takes an asynchronous, bouncy raw signal (button, relay contact, external trigger line) and passes it through a multi-flop synchronizer. It then accepts a level change only after the synchronized input has held the new level for a programmable number of consecutive clocks. The clean level `o_out` drives the edge detector's `i_in`, so each physical transition produces exactly one edge downstream.

---
 rtl/trigger_pkg.sv | 11 +
 rtl/synchronizer.sv | 30 +++
 rtl/debouncer.sv | 98 +++++++++
 tb/tb_debouncer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/trigger_pkg.sv
// Shared types and constants for the trigger input path.
package trigger_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_SETTLE = 1'b1
  } debouncer_state_t;

  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit; latency STAGES clocks, no backpressure.
module synchronizer
  import trigger_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  if (STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
    $error("synchronizer: STAGES must be >= 2");
  end

  logic [STAGES-1:0] sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync <= {STAGES{RESET_VAL}};
    end else begin
      sync <= {sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = sync[STAGES-1];

endmodule

// File: rtl/debouncer.sv
// Synchronizes a bouncy async input and accepts a level change only after DEBOUNCE_CYCLES stable clocks.
// Output change lands SYNC_STAGES+DEBOUNCE_CYCLES-1 edges after the new level is first sampled; no backpressure.
module debouncer
  import trigger_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 1000,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in,
  output logic o_out,
  output logic o_busy,
  output logic o_glitch
);

  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
    $error("debouncer: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("debouncer: DEBOUNCE_CYCLES must be >= 1");
  end

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic             s;
  debouncer_state_t state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             out_nxt;
  logic             glitch_nxt;

  synchronizer #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_LEVEL)
  ) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_in),
    .o_q   (s)
  );

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    out_nxt    = o_out;
    glitch_nxt = 1'b0;
    case (state)
      ST_STABLE: begin
        cnt_nxt = '0;
        if (s != o_out) begin
          // A single-cycle qualification needs no SETTLE visit.
          if (DEBOUNCE_CYCLES == 1) begin
            out_nxt = s;
          end else begin
            cnt_nxt   = CW'(1);
            state_nxt = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (s == o_out) begin
          cnt_nxt    = '0;
          state_nxt  = ST_STABLE;
          glitch_nxt = 1'b1;
        end else if (cnt == CNT_LAST) begin
          out_nxt   = s;
          cnt_nxt   = '0;
          state_nxt = ST_STABLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = ST_STABLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_STABLE;
      cnt      <= '0;
      o_out    <= RESET_LEVEL;
      o_busy   <= 1'b0;
      o_glitch <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      o_out    <= out_nxt;
      o_busy   <= (state_nxt == ST_SETTLE);
      o_glitch <= glitch_nxt;
    end
  end

endmodule

// File: tb/tb_debouncer.sv
// Directed bench for debouncer: vector table plus hand sequences for bounces, async reset and the one-cycle variant.
module tb_debouncer;

  logic clk = 1'b0;
  logic rst;
  logic in4, out4, busy4, glitch4;
  logic in1, out1, busy1, glitch1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  debouncer #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .RESET_LEVEL     (1'b0)
  ) dut4 (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_in     (in4),
    .o_out    (out4),
    .o_busy   (busy4),
    .o_glitch (glitch4)
  );

  debouncer #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (1),
    .RESET_LEVEL     (1'b0)
  ) dut1 (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_in     (in1),
    .o_out    (out1),
    .o_busy   (busy1),
    .o_glitch (glitch1)
  );

  typedef struct {
    logic in;
    logic out;
    logic busy;
    logic glitch;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   rises;
    int   glitches;
    logic prev_out;
    logic a1, a2;
    logic pat[21];

    // in, out, busy, glitch after the edge that samples 'in'
    // release from reset with input already high
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    // clean fall
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0};
    // two-cycle bounce rejected
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    in4 = 1'b1;
    in1 = 1'b0;
    #2;
    check("reset_out", out4, 1'b0);
    check("reset_busy", busy4, 1'b0);
    check("reset_glitch", glitch4, 1'b0);
    step();
    step();
    check("reset_held_out", out4, 1'b0);
    check("reset_held_busy", busy4, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      in4 = vecs[i].in;
      step();
      check($sformatf("vec%0d_out", i), out4, vecs[i].out);
      check($sformatf("vec%0d_busy", i), busy4, vecs[i].busy);
      check($sformatf("vec%0d_glitch", i), glitch4, vecs[i].glitch);
    end

    // bouncy press: pulses of 1, 3 and 2 cycles, then steady high from index 11
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
            1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    rises    = 0;
    glitches = 0;
    prev_out = out4;
    for (int i = 0; i < 21; i++) begin
      in4 = pat[i];
      step();
      check($sformatf("bouncy%0d_out", i), out4, (i >= 16) ? 1'b1 : 1'b0);
      if (out4 && !prev_out) rises++;
      if (glitch4) glitches++;
      prev_out = out4;
    end
    check_int("bouncy_rises", rises, 1);
    check_int("bouncy_glitches", glitches, 3);

    // async reset while qualifying a fall from a high output
    in4 = 1'b0;
    step();
    step();
    step();
    check("midsettle_busy_before", busy4, 1'b1);
    check("midsettle_out_before", out4, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("midsettle_out_async", out4, 1'b0);
    check("midsettle_busy_async", busy4, 1'b0);
    check("midsettle_glitch_async", glitch4, 1'b0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("post_rst%0d_out", i), out4, 1'b0);
      check($sformatf("post_rst%0d_busy", i), busy4, 1'b0);
      check($sformatf("post_rst%0d_glitch", i), glitch4, 1'b0);
    end

    // single-cycle qualification: output follows input two edges later
    a1 = 1'b0;
    a2 = 1'b0;
    for (int i = 0; i < 24; i++) begin
      in1 = ((i / 3) % 2) == 1;
      step();
      check($sformatf("db1_%0d_out", i), out1, a2);
      check($sformatf("db1_%0d_busy", i), busy1, 1'b0);
      check($sformatf("db1_%0d_glitch", i), glitch1, 1'b0);
      a2 = a1;
      a1 = in1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
